// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage bundle between the pipeline and the mul/div unit
interface muldiv_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Instr_valid;
   logic [5:0]            Exe_opcode;
   logic [5:0]            Function_opcode;
   logic [DATA_WIDTH-1:0] Read_data_1;
   logic [DATA_WIDTH-1:0] Read_data_2;
   logic                  Stall;
   logic                  Busy;
   logic [DATA_WIDTH-1:0] HI;
   logic [DATA_WIDTH-1:0] LO;
   logic [DATA_WIDTH-1:0] Hilo_result;
   logic                  Hilo_wr;
   logic                  Div_by_zero;
   modport master (
      output Instr_valid, Exe_opcode, Function_opcode, Read_data_1, Read_data_2,
      input  Stall, Busy, HI, LO, Hilo_result, Hilo_wr, Div_by_zero
   );
   modport slave (
      input  Instr_valid, Exe_opcode, Function_opcode, Read_data_1, Read_data_2,
      output Stall, Busy, HI, LO, Hilo_result, Hilo_wr, Div_by_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with fetch stall
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input logic              clock,
   input logic              reset,
   muldiv_sequencer_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
   logic [1:0]     state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   hi_r, lo_r, acc_hi, acc_lo, opb;
   logic           op_div, neg_q, neg_r, dz, busy_r;
   logic           dec, is_mul, is_div, is_sgn, start, rs_neg, rt_neg, div_ge;
   logic [5:0]     fn;
   logic [W-1:0]   rs, rt, abs_rs, abs_rt, q_fix, r_fix, hi_nxt, lo_nxt;
   logic [W:0]     mul_sum, div_sh, div_diff;
   logic [2*W-1:0] prod, prod_fix;
   assign fn      = bus.Function_opcode;
   assign rs      = bus.Read_data_1;
   assign rt      = bus.Read_data_2;
   assign dec     = bus.Instr_valid && bus.Exe_opcode == 6'h00;
   assign is_mul  = dec && (fn == F_MULT || fn == F_MULTU);
   assign is_div  = dec && (fn == F_DIV || fn == F_DIVU);
   assign is_sgn  = fn == F_MULT || fn == F_DIV;
   assign start   = state == IDLE && (is_mul || is_div);
   assign rs_neg  = is_sgn && rs[W-1];
   assign rt_neg  = is_sgn && rt[W-1];
   assign abs_rs  = rs_neg ? -rs : rs;
   assign abs_rt  = rt_neg ? -rt : rt;
   // Shift-add step: add multiplicand when the current multiplier bit is set, then shift the pair right.
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
   // Restoring step: partial remainder stays below the divisor, so bit W of the difference is the borrow.
   assign div_sh   = {acc_hi, acc_lo[W-1]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_ge   = ~div_diff[W];
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign q_fix    = dz ? '1 : neg_q ? -acc_lo : acc_lo;
   assign r_fix    = neg_r ? -acc_hi : acc_hi;
   assign hi_nxt   = op_div ? r_fix : prod_fix[2*W-1:W];
   assign lo_nxt   = op_div ? q_fix : prod_fix[W-1:0];
   // Sequencer: one start cycle, W iterations, one fix-up cycle, one cycle to let the held instruction retire.
   always_comb begin
      state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                  state == CALC ? (cnt == CW'(W-1) ? FIX : CALC) :
                  state == FIX  ? DONE : IDLE;
   end
   // Control and datapath state: latch magnitudes and signs at start, iterate in CALC.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         cnt    <= '0;
         op_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         opb    <= '0;
      end else begin
         state  <= state_nxt;
         busy_r <= state_nxt == CALC || state_nxt == FIX;
         if (start) begin
            cnt    <= '0;
            op_div <= is_div;
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= is_div && rs_neg;
            dz     <= is_div && rt == '0;
            acc_hi <= '0;
            acc_lo <= is_div ? abs_rs : abs_rt;
            opb    <= is_div ? abs_rt : abs_rs;
         end else if (state == CALC) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= op_div ? (div_ge ? div_diff[W-1:0] : div_sh[W-1:0]) : mul_sum[W:1];
            acc_lo <= op_div ? {acc_lo[W-2:0], div_ge} : {mul_sum[0], acc_lo[W-1:1]};
         end
      end
   end
   // HI/LO: whole-result write on the FIX edge, MTHI/MTLO only while idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (state == FIX) begin
         hi_r <= hi_nxt;
         lo_r <= lo_nxt;
      end else if (state == IDLE && dec) begin
         hi_r <= fn == F_MTHI ? rs : hi_r;
         lo_r <= fn == F_MTLO ? rs : lo_r;
      end
   end
   assign bus.Stall       = start || state == CALC || state == FIX;
   assign bus.Busy        = busy_r;
   assign bus.HI          = hi_r;
   assign bus.LO          = lo_r;
   assign bus.Div_by_zero = dz;
   assign bus.Hilo_wr     = dec && (fn == F_MFHI || fn == F_MFLO);
   assign bus.Hilo_result = dec && fn == F_MFHI ? hi_r : dec && fn == F_MFLO ? lo_r : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of mul/div results, stall timing, HI/LO moves and reset
module tb_muldiv_sequencer;
   logic clock = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   int sc, bc;
   logic [31:0] hm, dm;
   muldiv_sequencer_if #(.DATA_WIDTH(32)) bus();
   muldiv_sequencer #(.DATA_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic iv, input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock);
      #1;
      bus.Instr_valid = iv;
      bus.Exe_opcode = op;
      bus.Function_opcode = fn;
      bus.Read_data_1 = a;
      bus.Read_data_2 = b;
   endtask
   task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int s_cnt, output int b_cnt, output logic [31:0] hi_mid, output logic [31:0] dz_mid);
      drive(1'b1, 6'h00, fn, a, b);
      s_cnt = 0;
      b_cnt = 0;
      hi_mid = 'x;
      dz_mid = 'x;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!bus.Stall) break;
         s_cnt++;
         if (bus.Busy) b_cnt++;
         if (i == 20) begin
            hi_mid = bus.HI;
            dz_mid = {31'd0, bus.Div_by_zero};
         end
      end
      drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
      @(negedge clock);
   endtask
   initial begin
      reset = 1'b1;
      bus.Instr_valid = 1'b0;
      bus.Exe_opcode = '0;
      bus.Function_opcode = '0;
      bus.Read_data_1 = '0;
      bus.Read_data_2 = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_hi", bus.HI, 32'h0);
      chk("rst_lo", bus.LO, 32'h0);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
      chk("rst_dz", {31'd0, bus.Div_by_zero}, 32'd0);
      run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, sc, bc, hm, dm);
      chk("multu_stall_cycles", sc, 34);
      chk("multu_busy_cycles", bc, 33);
      chk("multu_hi_mid", hm, 32'h0);
      chk("multu_hi", bus.HI, 32'hFFFFFFFE);
      chk("multu_lo", bus.LO, 32'h00000001);
      chk("multu_after_stall", {31'd0, bus.Stall}, 32'd0);
      chk("multu_after_busy", {31'd0, bus.Busy}, 32'd0);
      run_op(6'h18, 32'hFFFFFFFD, 32'd7, sc, bc, hm, dm);
      chk("mult_stall_cycles", sc, 34);
      chk("mult_hi_mid", hm, 32'hFFFFFFFE);
      chk("mult_hi", bus.HI, 32'hFFFFFFFF);
      chk("mult_lo", bus.LO, 32'hFFFFFFEB);
      drive(1'b1, 6'h00, 6'h12, 32'd0, 32'd0);
      @(negedge clock);
      chk("mflo_result", bus.Hilo_result, 32'hFFFFFFEB);
      chk("mflo_wr", {31'd0, bus.Hilo_wr}, 32'd1);
      chk("mflo_stall", {31'd0, bus.Stall}, 32'd0);
      run_op(6'h18, 32'hFFFFFFFB, 32'hFFFFFFFA, sc, bc, hm, dm);
      chk("mult_negneg_hi", bus.HI, 32'h0);
      chk("mult_negneg_lo", bus.LO, 32'h0000001E);
      run_op(6'h1A, 32'hFFFFFFF9, 32'd2, sc, bc, hm, dm);
      chk("div_stall_cycles", sc, 34);
      chk("div_lo", bus.LO, 32'hFFFFFFFD);
      chk("div_hi", bus.HI, 32'hFFFFFFFF);
      run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, sc, bc, hm, dm);
      chk("div_ovf_lo", bus.LO, 32'h80000000);
      chk("div_ovf_hi", bus.HI, 32'h0);
      run_op(6'h1A, 32'd7, 32'hFFFFFFFE, sc, bc, hm, dm);
      chk("div_pos_neg_lo", bus.LO, 32'hFFFFFFFD);
      chk("div_pos_neg_hi", bus.HI, 32'h00000001);
      run_op(6'h1B, 32'd10, 32'd0, sc, bc, hm, dm);
      chk("divu_z_stall_cycles", sc, 34);
      chk("divu_z_dz_mid", dm, 32'd1);
      chk("divu_z_hi", bus.HI, 32'h0000000A);
      chk("divu_z_lo", bus.LO, 32'hFFFFFFFF);
      chk("divu_z_dz", {31'd0, bus.Div_by_zero}, 32'd1);
      run_op(6'h1A, 32'hFFFFFFF6, 32'd0, sc, bc, hm, dm);
      chk("div_z_neg_hi", bus.HI, 32'hFFFFFFF6);
      chk("div_z_neg_lo", bus.LO, 32'hFFFFFFFF);
      run_op(6'h19, 32'd6, 32'd7, sc, bc, hm, dm);
      chk("multu_dz_cleared_mid", dm, 32'd0);
      chk("multu_dz_cleared", {31'd0, bus.Div_by_zero}, 32'd0);
      chk("multu_small_hi", bus.HI, 32'h0);
      chk("multu_small_lo", bus.LO, 32'h0000002A);
      drive(1'b1, 6'h00, 6'h11, 32'h12345678, 32'd0);
      @(negedge clock);
      chk("mthi_stall", {31'd0, bus.Stall}, 32'd0);
      chk("mthi_wr", {31'd0, bus.Hilo_wr}, 32'd0);
      chk("mthi_result", bus.Hilo_result, 32'h0);
      chk("mthi_hi_before", bus.HI, 32'h0);
      drive(1'b1, 6'h00, 6'h10, 32'd0, 32'd0);
      @(negedge clock);
      chk("mfhi_hi", bus.HI, 32'h12345678);
      chk("mfhi_result", bus.Hilo_result, 32'h12345678);
      chk("mfhi_wr", {31'd0, bus.Hilo_wr}, 32'd1);
      chk("mfhi_stall", {31'd0, bus.Stall}, 32'd0);
      drive(1'b1, 6'h00, 6'h13, 32'hCAFEF00D, 32'd0);
      @(negedge clock);
      chk("mtlo_stall", {31'd0, bus.Stall}, 32'd0);
      drive(1'b1, 6'h00, 6'h12, 32'd0, 32'd0);
      @(negedge clock);
      chk("mflo2_result", bus.Hilo_result, 32'hCAFEF00D);
      chk("mtlo_hi_kept", bus.HI, 32'h12345678);
      drive(1'b1, 6'h23, 6'h18, 32'd3, 32'd3);
      @(negedge clock);
      chk("nonzero_op_stall", {31'd0, bus.Stall}, 32'd0);
      chk("nonzero_op_wr", {31'd0, bus.Hilo_wr}, 32'd0);
      drive(1'b1, 6'h00, 6'h20, 32'd3, 32'd3);
      @(negedge clock);
      chk("unknown_fn_stall", {31'd0, bus.Stall}, 32'd0);
      drive(1'b0, 6'h00, 6'h19, 32'd3, 32'd3);
      @(negedge clock);
      chk("invalid_stall", {31'd0, bus.Stall}, 32'd0);
      drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
      @(negedge clock);
      chk("no_effect_hi", bus.HI, 32'h12345678);
      chk("no_effect_lo", bus.LO, 32'hCAFEF00D);
      drive(1'b1, 6'h00, 6'h1B, 32'd100, 32'd7);
      repeat (11) @(posedge clock);
      #1;
      reset = 1'b1;
      bus.Instr_valid = 1'b0;
      @(negedge clock);
      chk("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("midrst_stall", {31'd0, bus.Stall}, 32'd0);
      chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("midrst_hi", bus.HI, 32'h0);
      chk("midrst_lo", bus.LO, 32'h0);
      @(negedge clock);
      chk("midrst_hold_stall", {31'd0, bus.Stall}, 32'd0);
      run_op(6'h1B, 32'd100, 32'd7, sc, bc, hm, dm);
      chk("divu_stall_cycles", sc, 34);
      chk("divu_lo", bus.LO, 32'h0000000E);
      chk("divu_hi", bus.HI, 32'h00000002);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
